// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several string producers share one UART
// transmit FSM. A requester that wins keeps the transmitter for every byte
// of its string (lock); ownership is released at the last byte, when the
// requester withdraws, or when the transmitter fails to report completion
// within TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_last,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              tx_en,
  output logic [7:0]        tx_byte,
  input  logic              tx_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  own_q,   own_d;
  logic [IDX_W-1:0]  ptr_q,   ptr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              lock_q,  lock_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [7:0]        req_bytes [NREQ];
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;

  // Unpack the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin search: first set request strictly after the pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((int'(ptr_q) + off) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and output decode; SEND is the only state that strobes ack/tx_en.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    own_d       = own_q;
    ptr_d       = ptr_q;
    tx_byte_d   = tx_byte_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    ack         = '0;
    tx_en       = 1'b0;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = SEND;
          own_d     = win_idx;
          grant_d   = ONE_HOT << win_idx;
          tx_byte_d = req_bytes[win_idx];
          lock_d    = ~req_last[win_idx];
        end
      end

      SEND: begin
        ack     = grant_q;
        tx_en   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (tx_done) begin
          // Completion wins over a simultaneous timeout.
          if (lock_q && req[own_q]) begin
            // Next byte of the same string: no arbitration in between.
            state_d   = SEND;
            tx_byte_d = req_bytes[own_q];
            lock_d    = ~req_last[own_q];
          end else begin
            state_d   = IDLE;
            ptr_d     = own_q;
            grant_d   = '0;
            lock_d    = 1'b0;
            tx_byte_d = 8'h00;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
          ptr_d       = own_q;
          grant_d     = '0;
          lock_d      = 1'b0;
          tx_byte_d   = 8'h00;
        end else begin
          // Leaving at CNT_MAX keeps the counter from ever wrapping.
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        lock_d    = 1'b0;
        tx_byte_d = 8'h00;
      end
    endcase
  end

  // State register; the pointer resets to the last index so requester 0 leads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      own_q     <= '0;
      ptr_q     <= PTR_RST;
      tx_byte_q <= 8'h00;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      tx_byte_q <= tx_byte_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign tx_byte = tx_byte_q;
  assign busy    = (state_q != IDLE);

endmodule
